alu_exec_seq: RTL

Parametrised successor to the ALU control decoder: it decodes alu_op/funct into the 4-bit ALU control code and executes the operation on WIDTH-bit operands.
- Results are registered behind a valid/ready handshake.
- An optional iterative multiply runs as a multi-cycle operation.
- Sits between the register-read stage and writeback/branch logic in the datapath.

---
 rtl/alu_ctrl_pkg.sv | 33 +++
 rtl/alu_ctrl_decode.sv | 44 ++++
 rtl/alu_exec_seq.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control decoder and the sequenced ALU:
// control codes, R-type funct values, main-control alu_op values and FSM states.
package alu_ctrl_pkg;

    localparam logic [3:0] CTRL_AND     = 4'b0000;
    localparam logic [3:0] CTRL_OR      = 4'b0001;
    localparam logic [3:0] CTRL_ADD     = 4'b0010;
    localparam logic [3:0] CTRL_SUB     = 4'b0110;
    localparam logic [3:0] CTRL_SLT     = 4'b0111;
    localparam logic [3:0] CTRL_MULT    = 4'b1000;
    localparam logic [3:0] CTRL_NOR     = 4'b1100;
    localparam logic [3:0] CTRL_ILLEGAL = 4'b1111;

    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;
    localparam logic [5:0] FUNCT_MULT = 6'b011000;

    localparam logic [1:0] ALU_OP_ADD     = 2'b00;
    localparam logic [1:0] ALU_OP_SUB     = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE   = 2'b10;
    localparam logic [1:0] ALU_OP_SUB_ALT = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational alu_op/funct decoder. Funct 011000 decodes as a multi-cycle
// mult only when ALU_MULT_EN is defined; otherwise it is illegal.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl,
    output logic       illegal,
    output logic       is_multi
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        alu_ctrl = CTRL_ADD;
        illegal  = 1'b0;
        is_multi = 1'b0;
        case (alu_op)
            ALU_OP_ADD:                 alu_ctrl = CTRL_ADD;
            ALU_OP_SUB, ALU_OP_SUB_ALT: alu_ctrl = CTRL_SUB;
            default: begin
                case (funct)
                    FUNCT_ADD: alu_ctrl = CTRL_ADD;
                    FUNCT_SUB: alu_ctrl = CTRL_SUB;
                    FUNCT_AND: alu_ctrl = CTRL_AND;
                    FUNCT_OR:  alu_ctrl = CTRL_OR;
                    FUNCT_SLT: alu_ctrl = CTRL_SLT;
                    FUNCT_NOR: alu_ctrl = CTRL_NOR;
`ifdef ALU_MULT_EN
                    FUNCT_MULT: begin
                        alu_ctrl = CTRL_MULT;
                        is_multi = 1'b1;
                    end
`endif
                    default: begin
                        alu_ctrl = CTRL_ILLEGAL;
                        illegal  = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_exec_seq.sv
// Decode-and-execute ALU with a registered valid/ready result. Define
// ALU_MULT_EN to add the WIDTH-cycle shift-add multiply (BUSY state).
module alu_exec_seq
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] opnd_a,
    input  logic [WIDTH-1:0] opnd_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [3:0]       alu_ctrl,
    output logic             illegal
);

    state_t           state, next_state;
    logic [3:0]       dec_ctrl;
    logic             dec_illegal;
    logic             dec_multi;
    logic             accept;
    logic [WIDTH-1:0] alu_res;

    alu_ctrl_decode u_decode (
        .alu_op   (alu_op),
        .funct    (funct),
        .alu_ctrl (dec_ctrl),
        .illegal  (dec_illegal),
        .is_multi (dec_multi)
    );

    assign accept = in_valid && in_ready;

    always_comb begin
        alu_res = '0;
        case (dec_ctrl)
            CTRL_ADD: alu_res = opnd_a + opnd_b;
            CTRL_SUB: alu_res = opnd_a - opnd_b;
            CTRL_AND: alu_res = opnd_a & opnd_b;
            CTRL_OR:  alu_res = opnd_a | opnd_b;
            CTRL_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(opnd_a) < $signed(opnd_b))};
            CTRL_NOR: alu_res = ~(opnd_a | opnd_b);
            default:  alu_res = '0;
        endcase
    end

`ifdef ALU_MULT_EN
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mcand, mplier, acc, acc_next;
    logic             mult_last;

    assign acc_next  = acc + (mplier[0] ? mcand : '0);
    assign mult_last = (state == BUSY) && (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept && dec_multi) begin
            cnt <= '0;
        end else if (state == BUSY) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // NOTE: the shift-add datapath is loaded on every accept, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept && dec_multi) begin
            mcand  <= opnd_a;
            mplier <= opnd_b;
            acc    <= '0;
        end else if (state == BUSY) begin
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            acc    <= acc_next;
        end
    end
`endif

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (in_valid) next_state = dec_multi ? BUSY : DONE;
`ifdef ALU_MULT_EN
            BUSY: next_state = mult_last ? DONE : BUSY;
`else
            BUSY: next_state = IDLE;
`endif
            DONE: begin
                if (out_ready) begin
                    if (in_valid) next_state = dec_multi ? BUSY : DONE;
                    else          next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
        out_valid = (state == DONE);
    end

    // Held outputs only load on a transition into DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            result   <= '0;
            zero     <= 1'b0;
            alu_ctrl <= 4'b0000;
            illegal  <= 1'b0;
        end else if (accept && !dec_multi) begin
            result   <= alu_res;
            zero     <= (alu_res == '0);
            alu_ctrl <= dec_ctrl;
            illegal  <= dec_illegal;
`ifdef ALU_MULT_EN
        end else if (mult_last) begin
            result   <= acc_next;
            zero     <= (acc_next == '0);
            alu_ctrl <= CTRL_MULT;
            illegal  <= 1'b0;
`endif
        end
    end

endmodule
